oam_dma_arbiter: RTL and testbench
==================================

# oam_dma_arbiter

Sprite-DMA controller and memory-bus arbiter between `cpu_top` and the single-port `mem`. A CPU write to the trigger address starts a 256-byte copy from page `{din,8'h00}` to the OAM data port. The block stalls the CPU through `rdy`, takes the memory bus, and sequences alternating read and write cycles. It returns the bus when the copy is done. In the system it sits between the CPU address/data pins and the `mem` instance; the testbench top instantiates it in place of the direct CPU-to-memory wiring.

## Interface
- `ADDR_WIDTH`, default 16: address bus width, matches `ADDR_WIDTH`.
- `DATA_WIDTH`, default 8: data width, matches `REG_WIDTH`.
- `TRIGGER_ADDR`, default 16'h4014: CPU write address that starts DMA.
- `DEST_ADDR`, default 16'h2004: fixed destination address for every DMA write.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  ADDR_WIDTH  CPU address.
- `cpu_we`  in  1  CPU write strobe (`!R_W_n`).
- `cpu_din`  in  DATA_WIDTH  CPU write data.
- `cpu_dout`  out  DATA_WIDTH  read data to CPU; always equals `mem_dout`.
- `cpu_rdy`  out  1  drives CPU `rdy`; low while DMA is pending or active.
- `mem_addr`  out  ADDR_WIDTH  address to `mem`.
- `mem_we`  out  1  write enable to `mem`.
- `mem_din`  out  DATA_WIDTH  write data to `mem`.
- `mem_dout`  in  DATA_WIDTH  read data from `mem`; valid within the cycle its address is driven.
- `dma_busy`  out  1  high in every state other than IDLE.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Registers:
  - `page` (8b), the source page.
  - `idx` (8b), the byte index.
  - `latch` (8b), the byte in flight.
  - `odd` (1b), toggles every clock from reset.
- IDLE:
  - Bus is passed through: `mem_addr=cpu_addr`, `mem_we=cpu_we`, `mem_din=cpu_din`.
  - When `cpu_we && cpu_addr==TRIGGER_ADDR`, the trigger write still reaches memory. Capture `page<=cpu_din` and `idx<=0`, then go to HALT.
- HALT:
  - `cpu_rdy=0`.
  - While `cpu_we=1`, the 6502 ignores `rdy` on write cycles. The CPU keeps the bus (pass-through) and the block stays in HALT.
  - When `cpu_we=0`, the CPU is stalled. Drive `mem_we=0` and `mem_addr=cpu_addr` as a dummy read.
  - Next state is READ if the next cycle has `odd=0`, otherwise ALIGN.
- ALIGN:
  - One dummy cycle: `mem_we=0`, `mem_addr=cpu_addr`.
  - Next state is READ.
- READ:
  - `mem_addr={page,idx}`, `mem_we=0`.
  - `latch<=mem_dout`, then go to WRITE.
- WRITE:
  - `mem_addr=DEST_ADDR`, `mem_we=1`, `mem_din=latch`.
  - If `idx==8'hFF`, go to IDLE. Otherwise `idx<=idx+1` and go to READ.
- Arbitration is strictly a function of state. Only pass-through states let `cpu_we` reach `mem_we`. DMA states never forward CPU writes.
- A trigger write seen outside IDLE is ignored, including a second `$4014` write landing in HALT.
- Source addressing:
  - `idx` wraps at 8 bits, so the source never leaves the page.
  - `page=8'hFF` reads `16'hFF00..16'hFFFF`.
  - `page=8'h20` may read the destination region; no special handling.

## Timing
- Reset value of every output:
  - `cpu_rdy=1`, `dma_busy=0`.
  - `mem_*` pass through the CPU inputs.
  - `cpu_dout=mem_dout`.
- Reset value of every register:
  - State is IDLE.
  - `page`, `idx`, `latch` and `odd` are all 0.
- Reset asserted mid-DMA aborts immediately. No further memory write occurs, and `cpu_rdy` is high while reset is held.
- `cpu_rdy` is registered from state: low from the cycle after the trigger edge until the cycle after the last WRITE.
- DMA length, counted from the first stalled HALT cycle through the last WRITE inclusive:
  - 513 cycles when no ALIGN is needed.
  - 514 cycles with ALIGN.
- Each additional CPU write cycle held in HALT adds one cycle.
- Exactly 256 `mem_we` pulses occur at `DEST_ADDR` per DMA.
- Write data for byte n equals the source byte at `{page,n}` as sampled during the READ cycle immediately preceding it.

## Structure
- Shared package (`PKG/pkg.v`):
  - `DMA_TRIGGER_ADDR` and `OAM_DATA_ADDR` defines.
  - `dma_state_t` enum typedef (IDLE, HALT, ALIGN, READ, WRITE).
- Single module, no sub-modules. The bus mux is a combinational block keyed on state. The FSM, `idx` counter and `odd` toggle sit in one `always_ff` with async reset.

## Test plan
- Memory `16'h0300+i = i^8'hA5` for i=0..255; CPU writes `8'h03` to `16'h4014` with `odd=0` at the first READ -> 256 writes to `16'h2004` carrying `A5,A4,...,5A`; `cpu_rdy` low for exactly 513 cycles.
- Same trigger with parity offset by one cycle -> one ALIGN cycle, 514-cycle stall, identical data sequence.
- `cpu_we` held high for 2 cycles after the trigger -> those writes reach memory unchanged; the stall extends by 2 cycles; no DMA access before `cpu_we` falls.
- `reset_n` pulsed low after the 100th DMA write -> state IDLE, `cpu_rdy=1`, `dma_busy=0`; no write to `16'h2004` after the reset edge.
- Page `8'hFF` -> reads `16'hFF00..16'hFFFF`; `idx` wraps without carry into the page; exactly 256 writes.
- CPU writes `16'h4015` and reads `16'h4014` -> no DMA; `dma_busy` stays 0; pure pass-through observed on `mem_*`.

Source files
------------

// File: rtl/oam_dma_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// oam_dma_arbiter_pkg
//   Shared constants and types for the sprite-DMA controller / bus arbiter.
//   - DMA_TRIGGER_ADDR : CPU write address that kicks off a sprite copy.
//   - OAM_DATA_ADDR    : fixed OAM data port every DMA byte is written to.
//   - ST_* encodings   : legacy-compatible state codes; dma_state_t names them.
// ----------------------------------------------------------------------------
package oam_dma_arbiter_pkg;

  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR    = 16'h2004;

  // Last byte index of a 256-byte page copy.
  localparam logic [7:0]  DMA_LAST_IDX     = 8'hFF;

  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_HALT  = 3'd1;
  localparam logic [2:0]  ST_ALIGN = 3'd2;
  localparam logic [2:0]  ST_READ  = 3'd3;
  localparam logic [2:0]  ST_WRITE = 3'd4;

  typedef enum logic [2:0] {
    DMA_IDLE  = ST_IDLE,
    DMA_HALT  = ST_HALT,
    DMA_ALIGN = ST_ALIGN,
    DMA_READ  = ST_READ,
    DMA_WRITE = ST_WRITE
  } dma_state_t;

endpackage : oam_dma_arbiter_pkg

// File: rtl/oam_dma_arbiter.sv
// ----------------------------------------------------------------------------
// oam_dma_arbiter
//   Sprite-DMA controller and memory-bus arbiter between the CPU and a
//   single-port memory. A CPU write of value P to TRIGGER_ADDR copies the 256
//   bytes at {P,8'h00}..{P,8'hFF} to DEST_ADDR, one byte per READ/WRITE pair,
//   while the CPU is held off through cpu_rdy.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   cpu_addr  in   CPU address
//   cpu_we    in   CPU write strobe
//   cpu_din   in   CPU write data
//   cpu_dout  out  read data to CPU (always mem_dout)
//   cpu_rdy   out  CPU ready; low while a DMA is pending or running
//   mem_addr  out  memory address
//   mem_we    out  memory write enable
//   mem_din   out  memory write data
//   mem_dout  in   memory read data, valid in the cycle its address is driven
//   dma_busy  out  high whenever the controller is not idle
// ----------------------------------------------------------------------------
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = ADDR_WIDTH'(DMA_TRIGGER_ADDR),
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR    = ADDR_WIDTH'(OAM_DATA_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  output logic                  cpu_rdy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  dma_busy
);

  dma_state_t            state_q, state_d;
  logic [7:0]            page_q,  page_d;
  logic [7:0]            idx_q,   idx_d;
  logic [DATA_WIDTH-1:0] latch_q, latch_d;
  // Free-running cycle parity; decides whether an ALIGN cycle is needed so
  // the first READ always lands on an even cycle.
  logic                  odd_q;

  logic                  trigger;

  assign trigger = cpu_we && (cpu_addr == TRIGGER_ADDR);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;

    case (state_q)
      DMA_IDLE: begin
        // The trigger write itself is still forwarded to memory by the mux.
        if (trigger) begin
          page_d  = cpu_din[7:0];
          idx_d   = 8'h00;
          state_d = DMA_HALT;
        end
      end

      DMA_HALT: begin
        // A 6502 ignores rdy on write cycles, so we wait for a read cycle
        // before the CPU is actually stalled. Any trigger seen here is ignored.
        if (!cpu_we) begin
          state_d = odd_q ? DMA_READ : DMA_ALIGN;
        end
      end

      DMA_ALIGN: begin
        state_d = DMA_READ;
      end

      DMA_READ: begin
        latch_d = mem_dout;
        state_d = DMA_WRITE;
      end

      DMA_WRITE: begin
        if (idx_q == DMA_LAST_IDX) begin
          state_d = DMA_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = DMA_READ;
        end
      end

      default: begin
        state_d = DMA_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others regardless of statement order.
    if (!reset_n) begin
      state_q <= DMA_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      latch_q <= '0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      odd_q   <= ~odd_q;
    end
  end

  // --------------------------------------------------------------------------
  // Bus mux: purely a function of state, so CPU writes only reach memory in
  // the pass-through states (IDLE, and HALT while the CPU is still writing).
  // --------------------------------------------------------------------------
  always_comb begin
    mem_addr = cpu_addr;
    mem_we   = cpu_we;
    mem_din  = cpu_din;

    case (state_q)
      DMA_IDLE: begin
        // full pass-through
      end

      DMA_HALT: begin
        // Pass-through while cpu_we is high; once it drops the stalled CPU's
        // read address is presented as a harmless dummy read.
        mem_we = cpu_we;
      end

      DMA_ALIGN: begin
        mem_we = 1'b0;
      end

      DMA_READ: begin
        mem_addr = ADDR_WIDTH'({page_q, idx_q});
        mem_we   = 1'b0;
      end

      DMA_WRITE: begin
        mem_addr = DEST_ADDR;
        mem_we   = 1'b1;
        mem_din  = latch_q;
      end

      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign cpu_dout = mem_dout;
  assign cpu_rdy  = (state_q == DMA_IDLE);
  assign dma_busy = (state_q != DMA_IDLE);

endmodule : oam_dma_arbiter

// File: tb/tb_oam_dma_arbiter.sv
// ----------------------------------------------------------------------------
// tb_oam_dma_arbiter
//   Directed bench for oam_dma_arbiter. Holds a 64 KiB byte memory on the
//   mem_* side, drives CPU cycles, and compares the DMA stream written to the
//   OAM port against hand-computed source patterns.
// ----------------------------------------------------------------------------
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        dma_busy;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_addr (cpu_addr),
    .cpu_we   (cpu_we),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_rdy  (cpu_rdy),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .dma_busy (dma_busy)
  );

  // Single-port memory: combinational read, write on the rising edge.
  logic [7:0] mem [0:65535];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  // Clock edges since reset release; its LSB is the cycle parity.
  int unsigned cyc;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // OAM write monitor: records each byte written to the OAM port and the
  // address presented in the cycle just before it (the source READ).
  logic [7:0]  wr_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] prev_addr;
  always @(negedge clk) begin
    if (reset_n && mem_we && mem_addr == 16'h2004) begin
      wr_q.push_back(mem_din);
      rd_q.push_back(prev_addr);
    end
    prev_addr = mem_addr;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] hold_addr [2] = '{16'h0500, 16'h4014};
  logic [7:0]  hold_data [2] = '{8'h11,    8'h07};

  // Triggers a DMA of 'page' after aligning to the cycle parity that makes an
  // ALIGN cycle needed (align=1) or not (align=0), with n_hold extra CPU write
  // cycles after the trigger. Returns the number of cycles cpu_rdy was low.
  task automatic run_dma(input logic [7:0] page, input bit align, input int n_hold,
                         output int low);
    bit done;
    do begin
      @(posedge clk); #1;
    end while ((cyc[0] ^ n_hold[0]) != align);
    wr_q.delete();
    rd_q.delete();
    cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_din = page;
    @(posedge clk); #1;
    low = 0;
    for (int k = 0; k < n_hold; k++) begin
      cpu_addr = hold_addr[k]; cpu_din = hold_data[k]; cpu_we = 1'b1;
      @(negedge clk);
      check("hold_we",   mem_we,   1'b1);
      check("hold_addr", mem_addr, hold_addr[k]);
      check("hold_din",  mem_din,  hold_data[k]);
      if (!cpu_rdy) low++;
      @(posedge clk); #1;
    end
    cpu_we = 1'b0; cpu_addr = 16'h8000; cpu_din = 8'h00;
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      if (cpu_rdy) done = 1'b1;
      else         low++;
    end
    check("rdy_timeout", done, 1'b1);
  endtask

  task automatic verify_seq(input logic [7:0] page, input logic [7:0] xr);
    check("wr_count", wr_q.size(), 256);
    for (int n = 0; n < 256; n++) begin
      if (n < wr_q.size()) begin
        check("wr_data", wr_q[n], 8'(n) ^ xr);
        check("rd_addr", rd_q[n], {page, 8'(n)});
      end
    end
  endtask

  int low;
  bit seen;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
      mem[16'hFF00 + i] = 8'(i) ^ 8'h3C;
    end
    mem[16'h4014] = 8'h5C;
    mem[16'h1234] = 8'h9E;

    // Reset state
    cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_din = 8'h00;
    #3;
    check("rst_rdy",  cpu_rdy,  1'b1);
    check("rst_busy", dma_busy, 1'b0);
    check("rst_addr", mem_addr, 16'h1234);
    check("rst_we",   mem_we,   1'b0);
    check("rst_dout", cpu_dout, 8'h9E);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Non-trigger write and a read of the trigger address: pure pass-through
    @(posedge clk); #1;
    cpu_addr = 16'h4015; cpu_we = 1'b1; cpu_din = 8'h77;
    @(negedge clk);
    check("pt_w_addr", mem_addr, 16'h4015);
    check("pt_w_we",   mem_we,   1'b1);
    check("pt_w_din",  mem_din,  8'h77);
    check("pt_w_busy", dma_busy, 1'b0);
    @(posedge clk); #1;
    cpu_addr = 16'h4014; cpu_we = 1'b0;
    @(negedge clk);
    check("pt_r_addr", mem_addr, 16'h4014);
    check("pt_r_we",   mem_we,   1'b0);
    check("pt_r_dout", cpu_dout, 8'h5C);
    @(posedge clk); #1;
    cpu_addr = 16'h8000;
    repeat (3) @(negedge clk);
    check("pt_busy",   dma_busy, 1'b0);
    check("pt_rdy",    cpu_rdy,  1'b1);
    check("pt_mem",    mem[16'h4015], 8'h77);

    // Page 03, no ALIGN cycle
    run_dma(8'h03, 1'b0, 0, low);
    check("noalign_low", low, 513);
    verify_seq(8'h03, 8'hA5);
    check("noalign_last", mem[16'h2004], 8'h5A);
    check("noalign_busy", dma_busy, 1'b0);

    // Page 03, one ALIGN cycle
    run_dma(8'h03, 1'b1, 0, low);
    check("align_low", low, 514);
    verify_seq(8'h03, 8'hA5);

    // Two CPU write cycles in HALT, the second a re-trigger that is ignored
    run_dma(8'h03, 1'b0, 2, low);
    check("hold_low", low, 515);
    verify_seq(8'h03, 8'hA5);
    check("hold_mem0",  mem[16'h0500], 8'h11);
    check("hold_mem1",  mem[16'h4014], 8'h07);

    // Top page: source stays in FF00..FFFF
    run_dma(8'hFF, 1'b0, 0, low);
    check("pageff_low", low, 513);
    verify_seq(8'hFF, 8'h3C);

    // Reset after the 100th DMA write
    @(posedge clk); #1;
    wr_q.delete(); rd_q.delete();
    cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_din = 8'h03;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h8000; cpu_din = 8'h00;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (wr_q.size() >= 100) seen = 1'b1;
    end
    check("rst100_seen", seen, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_rdy",  cpu_rdy,  1'b1);
    check("rst_mid_busy", dma_busy, 1'b0);
    check("rst_mid_we",   mem_we,   1'b0);
    check("rst_mid_addr", mem_addr, 16'h8000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_after_cnt",  wr_q.size(), 100);
    check("rst_after_mem",  mem[16'h2004], 8'hC6);
    check("rst_after_busy", dma_busy, 1'b0);
    check("rst_after_rdy",  cpu_rdy,  1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_oam_dma_arbiter
